// File: rtl/rob_cmpl_arb_if.sv
// Completion-port bundle: per-requester beats in, registered completion out.
// master = execution-unit side, slave = arbiter side.
interface rob_cmpl_arb_if #(
  parameter int unsigned K      = 4,
  parameter int unsigned N      = 16,
  parameter int unsigned CMPL_W = 32
);
  localparam int unsigned IDW = $clog2(N);
  localparam int unsigned SW  = $clog2(K);

  logic [K-1:0]        req_vld;
  logic [K*IDW-1:0]    req_id;
  logic [K*CMPL_W-1:0] req_data;
  logic [K-1:0]        req_rdy;

  logic                cmpl_vld;
  logic [IDW-1:0]      cmpl_id;
  logic [CMPL_W-1:0]   cmpl_data;
  logic [SW-1:0]       cmpl_src;
  logic                busy_r;

  modport master (
    output req_vld, req_id, req_data,
    input  req_rdy, cmpl_vld, cmpl_id, cmpl_data, cmpl_src, busy_r
  );

  modport slave (
    input  req_vld, req_id, req_data,
    output req_rdy, cmpl_vld, cmpl_id, cmpl_data, cmpl_src, busy_r
  );
endinterface

// File: rtl/rob_cmpl_arb.sv
// Round-robin arbiter sharing the ROB completion port among K requesters.
// Combinational grant, registered completion output one cycle later.
module rob_cmpl_arb #(
  parameter int unsigned K      = 4,
  parameter int unsigned N      = 16,
  parameter int unsigned CMPL_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           clear,
  rob_cmpl_arb_if.slave  bus
);
  localparam int unsigned IDW = $clog2(N);
  localparam int unsigned SW  = $clog2(K);

  logic [SW-1:0]     ptr_q, ptr_d;
  logic [SW-1:0]     gnt_idx;
  logic              gnt_vld;
  logic [K-1:0]      rdy;
  logic              busy_q, busy_d;
  logic              cmpl_vld_q;
  logic [IDW-1:0]    cmpl_id_q;
  logic [CMPL_W-1:0] cmpl_data_q;
  logic [SW-1:0]     cmpl_src_q;
  int unsigned       cand;

  // First valid requester scanning from ptr_q upward, wrapping at K-1.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int unsigned j = 0; j < K; j++) begin
      cand = 32'(ptr_q) + j;
      if (cand >= K) cand = cand - K;
      if (!gnt_vld && bus.req_vld[cand[SW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[SW-1:0];
      end
    end
    if (!en || clear || rst) gnt_vld = 1'b0;
  end

  always_comb begin
    rdy = '0;
    if (gnt_vld) rdy[gnt_idx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (clear) begin
      ptr_d = '0;
    end else if (gnt_vld) begin
      ptr_d = (gnt_idx == SW'(K - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  assign busy_d = clear ? 1'b0 : |(bus.req_vld & ~rdy);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      busy_q      <= 1'b0;
      cmpl_vld_q  <= 1'b0;
      cmpl_id_q   <= '0;
      cmpl_data_q <= '0;
      cmpl_src_q  <= '0;
    end else begin
      ptr_q      <= ptr_d;
      busy_q     <= busy_d;
      cmpl_vld_q <= gnt_vld;
      // Payload holds when idle; it is don't-care while cmpl_vld is low.
      if (gnt_vld) begin
        cmpl_id_q   <= bus.req_id[gnt_idx*IDW +: IDW];
        cmpl_data_q <= bus.req_data[gnt_idx*CMPL_W +: CMPL_W];
        cmpl_src_q  <= gnt_idx;
      end
    end
  end

  assign bus.req_rdy   = rdy;
  assign bus.cmpl_vld  = cmpl_vld_q;
  assign bus.cmpl_id   = cmpl_id_q;
  assign bus.cmpl_data = cmpl_data_q;
  assign bus.cmpl_src  = cmpl_src_q;
  assign bus.busy_r    = busy_q;
endmodule
